cfo_phase_gen: RTL and testbench

Per-sample phase generator for carrier frequency offset correction, placed directly upstream of the rotate stage. It accepts a per-sample phase increment from the CFO estimator and accumulates it once per valid sample. The accumulated phase is wrapped into [-PI, PI]. The block emits each I/Q sample together with its correction phase, aligned on one strobe, ready to drive the rotate stage's in_i/in_q/phase/input_strobe.

---
 rtl/cfo_phase_gen.sv | 172 +++++++++++++++++
 tb/tb_cfo_phase_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cfo_phase_gen.sv
// Purpose : CFO correction phase generator; accumulates a per-sample phase
//           increment, wraps it into [-PI, PI] and pairs it with each I/Q sample.
// Latency : 1 cycle from input_strobe to output_strobe; no backpressure (every
//           enabled input strobe produces exactly one output strobe).
//
// Ports:
//   clock, reset         - rising-edge clock, asynchronous active-high reset
//   enable               - clock enable; low freezes all state, output_strobe=0
//   in_i, in_q           - input sample, qualified by input_strobe
//   phase_inc            - signed per-sample increment, loaded on phase_inc_stb
//   clear                - synchronous return to IDLE (highest priority)
//   out_i, out_q         - registered sample, qualified by output_strobe
//   phase_out            - correction phase for that sample, within [-PI, PI]
//   tracking             - high while in TRACK state
//   inc_sat              - sticky: a loaded increment had to be clamped
module cfo_phase_gen #(
    parameter int PI          = 1608,
    parameter int PHASE_WIDTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [15:0]                   in_i,
    input  logic [15:0]                   in_q,
    input  logic                          input_strobe,
    input  logic signed [PHASE_WIDTH-1:0] phase_inc,
    input  logic                          phase_inc_stb,
    input  logic                          clear,
    output logic [15:0]                   out_i,
    output logic [15:0]                   out_q,
    output logic signed [PHASE_WIDTH-1:0] phase_out,
    output logic                          output_strobe,
    output logic                          tracking,
    output logic                          inc_sat
);

    // One extra bit of headroom so acc+inc never overflows before wrapping.
    localparam int SW = PHASE_WIDTH + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_TRACK = 1'b1;

    localparam logic signed [SW-1:0]          L_PI_X  = SW'(PI);
    localparam logic signed [SW-1:0]          L_NPI_X = -L_PI_X;
    localparam logic signed [PHASE_WIDTH-1:0] L_PI    = PHASE_WIDTH'(PI);
    localparam logic signed [PHASE_WIDTH-1:0] L_NPI   = -L_PI;
    localparam logic signed [PHASE_WIDTH-1:0] L_2PI   = PHASE_WIDTH'(2 * PI);
    localparam logic signed [PHASE_WIDTH-1:0] L_ZERO  = '0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]                    r_state;
    logic signed [PHASE_WIDTH-1:0] r_acc;
    logic signed [PHASE_WIDTH-1:0] r_inc;
    logic                          r_inc_sat;
    logic [15:0]                   r_out_i;
    logic [15:0]                   r_out_q;
    logic signed [PHASE_WIDTH-1:0] r_phase;
    logic                          r_out_stb;

    // ------------------------------------------------------------------
    // Increment saturation to [-PI, +PI]
    // ------------------------------------------------------------------
    logic signed [SW-1:0]          w_inc_x;
    logic signed [PHASE_WIDTH-1:0] w_inc_sat;
    logic                          w_inc_clamped;

    always_comb begin
        w_inc_x       = {phase_inc[PHASE_WIDTH-1], phase_inc};
        w_inc_sat     = phase_inc;
        w_inc_clamped = 1'b0;
        if (w_inc_x > L_PI_X) begin
            w_inc_sat     = L_PI;
            w_inc_clamped = 1'b1;
        end else if (w_inc_x < L_NPI_X) begin
            w_inc_sat     = L_NPI;
            w_inc_clamped = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator advance with single-step wrap.
    // The decision uses the full-width sum; the correction itself can be
    // done modulo 2^PHASE_WIDTH because the wrapped result always fits.
    // Exactly +PI / -PI fall through unchanged.
    // ------------------------------------------------------------------
    logic signed [SW-1:0]          w_sum;
    logic signed [PHASE_WIDTH-1:0] w_sum_lo;
    logic signed [PHASE_WIDTH-1:0] w_acc_next;

    always_comb begin
        w_sum    = {r_acc[PHASE_WIDTH-1], r_acc} + {r_inc[PHASE_WIDTH-1], r_inc};
        w_sum_lo = r_acc + r_inc;
        if (w_sum > L_PI_X) begin
            w_acc_next = w_sum_lo - L_2PI;
        end else if (w_sum < L_NPI_X) begin
            w_acc_next = w_sum_lo + L_2PI;
        end else begin
            w_acc_next = w_sum_lo;
        end
    end

    // Phase attached to a sample accepted this cycle: zero whenever the
    // sample starts (or ends) a track or the block is idle.
    logic signed [PHASE_WIDTH-1:0] w_phase_sel;

    always_comb begin
        w_phase_sel = r_acc;
        if (clear || phase_inc_stb || (r_state == S_IDLE)) begin
            w_phase_sel = L_ZERO;
        end
    end

    // ------------------------------------------------------------------
    // Output register: one strobe per accepted sample, data held on gaps
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_i   <= '0;
            r_out_q   <= '0;
            r_phase   <= '0;
            r_out_stb <= 1'b0;
        end else if (enable) begin
            r_out_stb <= input_strobe;
            if (input_strobe) begin
                r_out_i <= in_i;
                r_out_q <= in_q;
                r_phase <= w_phase_sel;
            end
        end else begin
            r_out_stb <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control: clear > load > normal tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_inc     <= '0;
            r_inc_sat <= 1'b0;
        end else if (enable) begin
            if (clear) begin
                r_state   <= S_IDLE;
                r_acc     <= '0;
                r_inc     <= '0;
                r_inc_sat <= 1'b0;
            end else if (phase_inc_stb) begin
                r_state   <= S_TRACK;
                r_inc     <= w_inc_sat;
                r_inc_sat <= r_inc_sat | w_inc_clamped;
                // A sample in the load cycle takes phase 0, so the next one
                // starts at the increment itself (already within range, so
                // the wrap is the identity). Without a sample, start at 0.
                r_acc     <= input_strobe ? w_inc_sat : L_ZERO;
            end else if ((r_state == S_TRACK) && input_strobe) begin
                r_acc <= w_acc_next;
            end
        end
    end

    assign out_i         = r_out_i;
    assign out_q         = r_out_q;
    assign phase_out     = r_phase;
    assign output_strobe = r_out_stb;
    assign tracking      = (r_state == S_TRACK);
    assign inc_sat       = r_inc_sat;

endmodule

// File: tb/tb_cfo_phase_gen.sv
module tb_cfo_phase_gen;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] in_i;
    logic [15:0] in_q;
    logic        input_strobe;
    logic signed [15:0] phase_inc;
    logic        phase_inc_stb;
    logic        clear;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic signed [15:0] phase_out;
    logic        output_strobe;
    logic        tracking;
    logic        inc_sat;

    int total;
    int bad;

    cfo_phase_gen #(.PI(1608), .PHASE_WIDTH(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .in_i          (in_i),
        .in_q          (in_q),
        .input_strobe  (input_strobe),
        .phase_inc     (phase_inc),
        .phase_inc_stb (phase_inc_stb),
        .clear         (clear),
        .out_i         (out_i),
        .out_q         (out_q),
        .phase_out     (phase_out),
        .output_strobe (output_strobe),
        .tracking      (tracking),
        .inc_sat       (inc_sat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, clock once, land 1 time unit after the edge.
    task automatic cyc(input logic stb, input logic ld, input logic cl,
                       input int inc, input int ii);
        input_strobe  = stb;
        phase_inc_stb = ld;
        clear         = cl;
        phase_inc     = 16'(inc);
        in_i          = 16'(ii);
        in_q          = 16'(ii + 1000);
        @(posedge clock);
        #1;
        phase_inc_stb = 1'b0;
        clear         = 1'b0;
    endtask

    // Expect a valid output sample carrying sample id ii and phase ph.
    task automatic exp_smp(input string tag, input int ph, input int ii);
        chk({tag, "_stb"}, 32'(output_strobe), 1);
        chk({tag, "_ph"}, $signed(phase_out), ph);
        chk({tag, "_i"}, $signed(out_i), ii);
        chk({tag, "_q"}, $signed(out_q), ii + 1000);
    endtask

    initial begin
        int t_neg500 [6];
        int t_p804   [5];
        int t_n804   [4];
        int t_sat    [4];
        int e;

        t_neg500 = '{0, -500, -1000, -1500, 1216, 716};
        t_p804   = '{0, 804, 1608, -804, 0};
        t_n804   = '{0, -804, -1608, 804};
        t_sat    = '{0, 1608, 0, 1608};

        total = 0;
        bad   = 0;
        reset = 1'b0;
        enable = 1'b1;
        in_i = '0;
        in_q = '0;
        input_strobe = 1'b0;
        phase_inc = '0;
        phase_inc_stb = 1'b0;
        clear = 1'b0;

        // Reset state
        #2 reset = 1'b1;
        #1;
        chk("rst_stb", 32'(output_strobe), 0);
        chk("rst_ph", $signed(phase_out), 0);
        chk("rst_i", $signed(out_i), 0);
        chk("rst_trk", 32'(tracking), 0);
        chk("rst_sat", 32'(inc_sat), 0);
        @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock);
        #1;

        // IDLE sample: phase 0, not tracking
        cyc(1, 0, 0, 0, 11);
        exp_smp("idle", 0, 11);
        chk("idle_trk", 32'(tracking), 0);

        // inc=100, 20 samples: 0..1600, then wrap to -1516, -1416, -1316
        for (int k = 0; k < 20; k++) begin
            cyc(1, (k == 0), 0, 100, 20 + k);
            e = (k <= 16) ? 100 * k : 100 * k - 3216;
            exp_smp($sformatf("inc100_%0d", k), e, 20 + k);
            chk("inc100_trk", 32'(tracking), 1);
        end
        // Gap: no strobe, data held
        cyc(0, 0, 0, 0, 77);
        chk("gap_stb", 32'(output_strobe), 0);
        chk("gap_ph_hold", $signed(phase_out), -1316);
        chk("gap_i_hold", $signed(out_i), 39);

        // inc=-500 with wrap below -PI
        for (int k = 0; k < 6; k++) begin
            cyc(1, (k == 0), 0, -500, 100 + k);
            exp_smp($sformatf("neg500_%0d", k), t_neg500[k], 100 + k);
            chk("neg500_trk", 32'(tracking), 1);
        end

        // Boundary +PI kept
        for (int k = 0; k < 5; k++) begin
            cyc(1, (k == 0), 0, 804, 200 + k);
            exp_smp($sformatf("p804_%0d", k), t_p804[k], 200 + k);
        end
        // Boundary -PI kept
        for (int k = 0; k < 4; k++) begin
            cyc(1, (k == 0), 0, -804, 210 + k);
            exp_smp($sformatf("n804_%0d", k), t_n804[k], 210 + k);
        end
        chk("nosat", 32'(inc_sat), 0);

        // Saturation: 2000 clamps to 1608
        for (int k = 0; k < 4; k++) begin
            cyc(1, (k == 0), 0, 2000, 220 + k);
            exp_smp($sformatf("sat_%0d", k), t_sat[k], 220 + k);
            chk("sat_flag", 32'(inc_sat), 1);
        end
        // Clear with a sample in the same cycle
        cyc(1, 0, 1, 0, 230);
        exp_smp("clr", 0, 230);
        chk("clr_sat", 32'(inc_sat), 0);
        chk("clr_trk", 32'(tracking), 0);
        cyc(1, 0, 0, 0, 231);
        exp_smp("clr_next", 0, 231);

        // Strobe every 3rd cycle
        cyc(1, 1, 0, 100, 300);
        exp_smp("gap3_0", 0, 300);
        cyc(0, 0, 0, 0, 0);
        chk("gap3_stb_a", 32'(output_strobe), 0);
        cyc(0, 0, 0, 0, 0);
        chk("gap3_i_hold", $signed(out_i), 300);
        cyc(1, 0, 0, 0, 301);
        exp_smp("gap3_1", 100, 301);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("gap3_stb_b", 32'(output_strobe), 0);
        cyc(1, 0, 0, 0, 302);
        exp_smp("gap3_2", 200, 302);

        // enable low for 5 cycles with strobes offered: nothing moves
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 0, 0, 999);
            chk("dis_stb", 32'(output_strobe), 0);
            chk("dis_ph", $signed(phase_out), 200);
            chk("dis_i", $signed(out_i), 302);
        end
        enable = 1'b1;
        cyc(1, 0, 0, 0, 303);
        exp_smp("resume", 300, 303);

        // Load without a sample: acc restarts at 0
        cyc(0, 1, 0, 100, 0);
        chk("ld_nosmp_stb", 32'(output_strobe), 0);
        chk("ld_nosmp_trk", 32'(tracking), 1);
        cyc(1, 0, 0, 0, 310);
        exp_smp("ld_nosmp_0", 0, 310);
        cyc(1, 0, 0, 0, 311);
        exp_smp("ld_nosmp_1", 100, 311);

        // clear wins over a simultaneous load
        cyc(1, 1, 1, 500, 320);
        exp_smp("clr_ld", 0, 320);
        chk("clr_ld_trk", 32'(tracking), 0);
        cyc(1, 0, 0, 0, 321);
        exp_smp("clr_ld_next", 0, 321);

        // Async reset mid-track
        cyc(1, 1, 0, 100, 330);
        cyc(1, 0, 0, 0, 331);
        exp_smp("pre_rst", 100, 331);
        input_strobe = 1'b1;
        in_i = 16'd332;
        #3 reset = 1'b1;
        #1;
        chk("arst_stb", 32'(output_strobe), 0);
        chk("arst_ph", $signed(phase_out), 0);
        chk("arst_i", $signed(out_i), 0);
        chk("arst_q", $signed(out_q), 0);
        chk("arst_trk", 32'(tracking), 0);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post_rst_stb", 32'(output_strobe), 1);
        chk("post_rst_ph", $signed(phase_out), 0);
        cyc(1, 0, 0, 0, 340);
        exp_smp("post_rst", 0, 340);
        chk("post_rst_trk", 32'(tracking), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
